util_upack2_timestamp: RTL and testbench
========================================

Name: util_upack2_timestamp

Overview:
TX-path unpacker between a DMA AXI-Stream source and per-channel DAC sample FIFOs. It splits wide DMA beats into 16-bit samples and distributes them, in order, across the currently enabled channels, one sample per enabled channel per read strobe. Optional in-band timestamp gating holds each packet until the free-running `timestamp` reaches the packet's header value.

Parameters:
- NUM_OF_CHANNELS, 4: channel count; ports are enable_0..3 and fifo_rd_data_0..3.
- SAMPLE_DATA_WIDTH, 16: bits per sample.
- SAMPLES_PER_CHANNEL, 1: samples per channel per read strobe; only 1 is supported.
- DMA_DATA_WIDTH, 128: s_axis_data width, i.e. 8 sample slots per beat.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- timestamp  in  64  free-running sample-time counter.
- timestamp_every  in  32  samples per channel per packet; 0 disables timestamp mode.
- enable_0..enable_3  in  1 each  channel enables; static while out of reset.
- fifo_rd_en  in  1  consumer requests one sample set.
- fifo_rd_valid  out  1  fifo_rd_data_* valid this cycle.
- fifo_rd_underflow  out  1  a request could not be served.
- fifo_rd_data_0..3  out  16 each  per-channel sample.
- s_axis_valid  in  1  DMA beat valid.
- s_axis_ready  out  1  DMA beat accepted when valid & ready.
- s_axis_xfer_req  in  1  DMA transfer active.
- s_axis_data  in  128  beat; slot i = bits [16i+:16], slot 0 is the oldest sample.

Behaviour:
- Reset (async):
  - Sample buffer count 0, read pointer 0, timestamp state IDLE.
  - All outputs 0, including s_axis_ready.
- N = number of enabled channels. N=0 means the block never asserts valid or underflow.
- Sample buffer holds 16 samples.
  - s_axis_ready = xfer_req & (count <= 8) & not in reset.
  - An accepted beat appends its 8 samples in slot order.
- Read: if fifo_rd_en and count >= N (count sampled at cycle start) and not gated, the next N samples are consumed.
  - Sample j goes to the j-th enabled channel in ascending channel index (channel 0 first).
  - Registered result: fifo_rd_valid=1 on the next cycle with the data. One-cycle latency.
  - Disabled channels output 0.
- Samples carry across beat boundaries, e.g. N=3.
- Underflow: if fifo_rd_en and data is unavailable and not gated, the next cycle has fifo_rd_valid=0, fifo_rd_underflow=1, and data held at the previous value.
- When fifo_rd_en=0, the next cycle has valid=0 and underflow=0.
- A beat accepted in the same cycle as a read is not usable for that read.
- Timestamp mode (timestamp_every != 0), states:
  - HDR: the next beat is a header; bits [63:0] are the target time and bits [127:64] are ignored. The whole beat is consumed.
  - WAIT: reads are gated, with valid=0 and underflow=0, until timestamp >= target (unsigned). A header already in the past is released immediately.
  - RUN: emit timestamp_every sample sets. Then discard the remaining samples of the final partially used beat and return to HDR.
- With timestamp_every = 0 the block stays in plain streaming mode.
- s_axis_xfer_req = 0:
  - Clears the buffer and returns to HDR (or streaming).
  - Outputs valid=0 and underflow=0.
- Enables and timestamp_every are sampled only after reset. Changing them requires a reset pulse.

Decomposition:
- Package `util_upack2_timestamp_pkg`:
  - Localparams SLOTS_PER_BEAT = DMA_DATA_WIDTH/SAMPLE_DATA_WIDTH and BUF_SLOTS = 2*SLOTS_PER_BEAT.
  - Timestamp state enum {STREAM, HDR, WAIT, RUN}.
- One sub-module, `upack_sample_router`: combinational mapping of buffer window plus enable vector to per-channel outputs, using a prefix count of enables.

Test Plan:
- Enable only channel 3. Six beats carrying samples 1..48 with fifo_rd_en held high -> 48 valid cycles, ch3 = 0x0001..0x0030 in order. Underflow appears only during the initial fill.
- All four channels enabled -> sets (1,2,3,4), (5,6,7,8), ... through (45,46,47,48). s_axis_ready pulses once every 2 reads.
- Channels 0, 1, 2 enabled -> (1,2,3), (4,5,6), (7,8,9) crossing the beat boundary ... (46,47,48). No lost or duplicated samples.
- Channels 0 and 2 enabled -> ch0 = odd samples, ch2 = even samples. ch1 and ch3 read 0.
- fifo_rd_en high with s_axis_valid low after reset -> underflow=1 from cycle 2, valid=0. Asserting reset mid-stream -> all outputs 0 immediately.
- timestamp_every=4, header 100, timestamp counting from 90 -> no valid until timestamp >= 100. Then exactly 4 sets are emitted, the partial beat is discarded, and the next beat is treated as a header.

Source files
------------

// File: rtl/util_upack2_timestamp_pkg.sv
// util_upack2_timestamp_pkg: shared buffer geometry and timestamp-gating states
package util_upack2_timestamp_pkg;
    localparam int SAMPLE_BITS = 16;
    localparam int DMA_BITS = 128;
    localparam int SLOTS_PER_BEAT = DMA_BITS / SAMPLE_BITS;
    localparam int BUF_SLOTS = 2 * SLOTS_PER_BEAT;
    typedef enum logic [1:0] {STREAM, HDR, WAIT, RUN} ts_state_t;
endpackage

// File: rtl/util_upack2_timestamp_sample_router.sv
// upack_sample_router: hands consecutive window samples to enabled channels in ascending order
module upack_sample_router #(
    parameter int NUM_OF_CHANNELS = 4,
    parameter int SAMPLE_DATA_WIDTH = 16
) (
    input  logic [NUM_OF_CHANNELS-1:0][SAMPLE_DATA_WIDTH-1:0] window,
    input  logic [NUM_OF_CHANNELS-1:0]                        enable,
    output logic [NUM_OF_CHANNELS-1:0][SAMPLE_DATA_WIDTH-1:0] data
);
    localparam int IW = NUM_OF_CHANNELS > 1 ? $clog2(NUM_OF_CHANNELS) : 1;
    logic [IW-1:0] slot [NUM_OF_CHANNELS];
    always_comb begin
        slot[0] = '0;
        for (int i = 1; i < NUM_OF_CHANNELS; i++) slot[i] = slot[i-1] + IW'(enable[i-1]);
        for (int i = 0; i < NUM_OF_CHANNELS; i++) data[i] = enable[i] ? window[slot[i]] : '0;
    end
endmodule

// File: rtl/util_upack2_timestamp.sv
// util_upack2_timestamp: splits DMA beats into per-channel DAC samples with optional
// in-band timestamp gating of each packet.
module util_upack2_timestamp
    import util_upack2_timestamp_pkg::*;
#(
    parameter int NUM_OF_CHANNELS = 4,
    parameter int SAMPLE_DATA_WIDTH = SAMPLE_BITS,
    parameter int SAMPLES_PER_CHANNEL = 1,
    parameter int DMA_DATA_WIDTH = DMA_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [63:0]                  timestamp,
    input  logic [31:0]                  timestamp_every,
    input  logic                         enable_0,
    input  logic                         enable_1,
    input  logic                         enable_2,
    input  logic                         enable_3,
    input  logic                         fifo_rd_en,
    output logic                         fifo_rd_valid,
    output logic                         fifo_rd_underflow,
    output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_0,
    output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_1,
    output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_2,
    output logic [SAMPLE_DATA_WIDTH-1:0] fifo_rd_data_3,
    input  logic                         s_axis_valid,
    output logic                         s_axis_ready,
    input  logic                         s_axis_xfer_req,
    input  logic [DMA_DATA_WIDTH-1:0]    s_axis_data
);
    localparam int PW = $clog2(BUF_SLOTS);
    localparam int HW = 64 / SAMPLE_DATA_WIDTH;
    localparam logic [PW:0] BEAT = (PW+1)'(SLOTS_PER_BEAT);
    localparam logic [PW-1:0] BEAT_MASK = PW'(SLOTS_PER_BEAT - 1);

    logic [SAMPLE_DATA_WIDTH-1:0] mem [BUF_SLOTS];
    logic [NUM_OF_CHANNELS-1:0][SAMPLE_DATA_WIDTH-1:0] window, routed, data_q;
    logic [NUM_OF_CHANNELS-1:0] en;
    logic [PW:0] count, count_nxt, need, drop;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt, wr_ptr, step_ptr, align_ptr;
    logic [63:0] target;
    logic [31:0] sets, sets_nxt;
    logic ts_mode, acc, gate, live, rd, last, hdr_take;
    ts_state_t state, state_nxt;

    assign en = {enable_3, enable_2, enable_1, enable_0};
    assign ts_mode = |timestamp_every;
    assign need = (PW+1)'($countones(en) * SAMPLES_PER_CHANNEL);
    assign wr_ptr = rd_ptr + count[PW-1:0];
    // Hold off the DMA for one cycle after reset in timestamp mode so the first beat is parsed as a header
    assign s_axis_ready = ~reset & s_axis_xfer_req & (count <= BEAT) & ~(ts_mode & state == STREAM);
    assign acc = s_axis_valid & s_axis_ready;
    assign gate = state == WAIT && timestamp < target;
    assign live = (state == STREAM && !ts_mode) || state == RUN || (state == WAIT && !gate);
    assign rd = s_axis_xfer_req & fifo_rd_en & live & |need & (count >= need);
    assign step_ptr = rd_ptr + need[PW-1:0];
    // Beats always land on beat-aligned slots, so the packet tail is dropped by aligning up
    assign align_ptr = (step_ptr + BEAT_MASK) & ~BEAT_MASK;
    assign drop = {1'b0, align_ptr - step_ptr};
    assign last = rd && state != STREAM && sets + 32'd1 == timestamp_every;
    assign hdr_take = s_axis_xfer_req && state == HDR && count >= BEAT;

    always_comb begin
        window = '0;
        for (int j = 0; j < NUM_OF_CHANNELS; j++) window[j] = mem[rd_ptr + PW'(j)];
    end

    upack_sample_router #(
        .NUM_OF_CHANNELS(NUM_OF_CHANNELS),
        .SAMPLE_DATA_WIDTH(SAMPLE_DATA_WIDTH)
    ) u_router (
        .window(window),
        .enable(en),
        .data(routed)
    );

    always_comb begin
        count_nxt = count;
        rd_ptr_nxt = rd_ptr;
        state_nxt = state;
        sets_nxt = sets;
        if (!s_axis_xfer_req) begin
            count_nxt = '0;
            rd_ptr_nxt = '0;
            state_nxt = ts_mode ? HDR : STREAM;
            sets_nxt = '0;
        end else begin
            if (state == STREAM && ts_mode) state_nxt = HDR;
            if (hdr_take) begin
                rd_ptr_nxt = rd_ptr + BEAT[PW-1:0];
                count_nxt = count - BEAT;
                state_nxt = WAIT;
            end
            if (rd) begin
                rd_ptr_nxt = step_ptr;
                count_nxt = count - need;
                state_nxt = state == STREAM ? STREAM : RUN;
                sets_nxt = state == STREAM ? sets : sets + 32'd1;
            end
            if (last) begin
                rd_ptr_nxt = align_ptr;
                count_nxt = count - need - drop;
                state_nxt = HDR;
                sets_nxt = '0;
            end
            count_nxt = acc ? count_nxt + BEAT : count_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            rd_ptr <= '0;
            state <= STREAM;
            sets <= '0;
            target <= '0;
            fifo_rd_valid <= 1'b0;
            fifo_rd_underflow <= 1'b0;
            data_q <= '0;
        end else begin
            count <= count_nxt;
            rd_ptr <= rd_ptr_nxt;
            state <= state_nxt;
            sets <= sets_nxt;
            fifo_rd_valid <= rd;
            fifo_rd_underflow <= s_axis_xfer_req & fifo_rd_en & |need & ~gate & ~rd;
            if (rd) data_q <= routed;
            if (hdr_take)
                for (int k = 0; k < HW; k++)
                    target[SAMPLE_DATA_WIDTH*k +: SAMPLE_DATA_WIDTH] <= mem[rd_ptr + PW'(k)];
        end
    end

    always_ff @(posedge clk) begin
        if (acc)
            for (int k = 0; k < SLOTS_PER_BEAT; k++)
                mem[wr_ptr + PW'(k)] <= s_axis_data[SAMPLE_DATA_WIDTH*k +: SAMPLE_DATA_WIDTH];
    end

    assign fifo_rd_data_0 = data_q[0];
    assign fifo_rd_data_1 = data_q[1];
    assign fifo_rd_data_2 = data_q[2];
    assign fifo_rd_data_3 = data_q[3];
endmodule

// File: tb/tb_util_upack2_timestamp.sv
// tb_util_upack2_timestamp: scoreboard bench for the DMA-to-DAC unpacker
module tb_util_upack2_timestamp;
    logic clk = 0, reset = 1;
    logic [63:0] timestamp = 0;
    logic [31:0] timestamp_every = 0;
    logic enable_0 = 0, enable_1 = 0, enable_2 = 0, enable_3 = 0;
    logic fifo_rd_en = 0, fifo_rd_valid, fifo_rd_underflow;
    logic [15:0] fifo_rd_data_0, fifo_rd_data_1, fifo_rd_data_2, fifo_rd_data_3;
    logic s_axis_valid = 0, s_axis_ready, s_axis_xfer_req = 0;
    logic [127:0] s_axis_data = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [63:0] min_ts;
    } exp_t;
    exp_t exp_q[$];
    int tests = 0, fails = 0;
    bit uf_chk = 0, started = 0, ts_run = 0;

    util_upack2_timestamp dut (
        .clk(clk), .reset(reset), .timestamp(timestamp), .timestamp_every(timestamp_every),
        .enable_0(enable_0), .enable_1(enable_1), .enable_2(enable_2), .enable_3(enable_3),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_valid(fifo_rd_valid), .fifo_rd_underflow(fifo_rd_underflow),
        .fifo_rd_data_0(fifo_rd_data_0), .fifo_rd_data_1(fifo_rd_data_1),
        .fifo_rd_data_2(fifo_rd_data_2), .fifo_rd_data_3(fifo_rd_data_3),
        .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
        .s_axis_xfer_req(s_axis_xfer_req), .s_axis_data(s_axis_data)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (ts_run) timestamp = timestamp + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Monitor: pops one expected set per valid output
    initial begin
        exp_t e;
        logic [63:0] got;
        forever begin
            @(posedge clk);
            #1;
            got = {fifo_rd_data_3, fifo_rd_data_2, fifo_rd_data_1, fifo_rd_data_0};
            if (!reset && fifo_rd_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_valid: got %h, required no valid", got);
                end else begin
                    e = exp_q.pop_front();
                    started = 1;
                    if (got !== e.d || timestamp < e.min_ts) begin
                        fails++;
                        $display("FAIL sample_set: got %h at ts %0d, required %h at ts >= %0d",
                                 got, timestamp, e.d, e.min_ts);
                    end
                end
            end
            if (!reset && uf_chk && started && exp_q.size() > 0) begin
                tests++;
                if (fifo_rd_underflow) begin
                    fails++;
                    $display("FAIL mid_stream_underflow: got 1, required 0");
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    function automatic logic [63:0] mkset(input logic [3:0] en, input int base);
        logic [63:0] r = '0;
        int k = 0;
        for (int i = 0; i < 4; i++)
            if (en[i]) begin
                r[16*i +: 16] = 16'(base + k);
                k++;
            end
        return r;
    endfunction

    function automatic logic [127:0] beat(input int base);
        logic [127:0] b;
        for (int k = 0; k < 8; k++) b[16*k +: 16] = 16'(base + k);
        return b;
    endfunction

    task automatic send(input logic [127:0] d);
        int t = 0;
        s_axis_data = d;
        s_axis_valid = 1;
        while (!s_axis_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got ready 0, required 1");
        end
        @(negedge clk);
        s_axis_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset(input logic [3:0] en, input logic [31:0] every);
        @(negedge clk);
        reset = 1;
        {enable_3, enable_2, enable_1, enable_0} = en;
        timestamp_every = every;
        fifo_rd_en = 0;
        s_axis_valid = 0;
        s_axis_xfer_req = 1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(fifo_rd_valid), 64'd0);
        chk("rst_underflow", 64'(fifo_rd_underflow), 64'd0);
        chk("rst_ready", 64'(s_axis_ready), 64'd0);
        chk("rst_data", {fifo_rd_data_3, fifo_rd_data_2, fifo_rd_data_1, fifo_rd_data_0}, 64'd0);
        exp_q.delete();
        started = 0;
        reset = 0;
        @(negedge clk);
        chk("post_rst_ready", 64'(s_axis_ready), 64'd1);
    endtask

    task automatic run_stream(input logic [3:0] en);
        int n = $countones(en);
        do_reset(en, 0);
        uf_chk = 1;
        for (int s = 0; s < 48 / n; s++) exp_q.push_back('{d: mkset(en, s * n + 1), min_ts: 64'd0});
        fifo_rd_en = 1;
        for (int b = 0; b < 6; b++) send(beat(8 * b + 1));
        drain();
        fifo_rd_en = 0;
        uf_chk = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        run_stream(4'b1000);
        run_stream(4'b1111);
        run_stream(4'b0111);
        run_stream(4'b0101);

        // Underflow with no DMA data, then release of the request
        do_reset(4'b1111, 0);
        fifo_rd_en = 1;
        repeat (2) @(negedge clk);
        chk("uf_flag", 64'(fifo_rd_underflow), 64'd1);
        chk("uf_valid", 64'(fifo_rd_valid), 64'd0);
        chk("uf_data_held", {fifo_rd_data_3, fifo_rd_data_2, fifo_rd_data_1, fifo_rd_data_0}, 64'd0);
        fifo_rd_en = 0;
        @(negedge clk);
        chk("idle_uf", 64'(fifo_rd_underflow), 64'd0);

        // Reset asserted while a valid set is on the outputs
        exp_q.push_back('{d: 64'h0004_0003_0002_0001, min_ts: 64'd0});
        send(beat(1));
        fifo_rd_en = 1;
        @(negedge clk);
        chk("mid_valid_before", 64'(fifo_rd_valid), 64'd1);
        reset = 1;
        #1;
        chk("mid_rst_valid", 64'(fifo_rd_valid), 64'd0);
        chk("mid_rst_data", {fifo_rd_data_3, fifo_rd_data_2, fifo_rd_data_1, fifo_rd_data_0}, 64'd0);
        chk("mid_rst_ready", 64'(s_axis_ready), 64'd0);

        // Dropping xfer_req flushes the buffer
        do_reset(4'b0001, 0);
        send(beat(1));
        s_axis_xfer_req = 0;
        fifo_rd_en = 1;
        @(negedge clk);
        chk("xfer_low_ready", 64'(s_axis_ready), 64'd0);
        @(negedge clk);
        chk("xfer_low_valid", 64'(fifo_rd_valid), 64'd0);
        chk("xfer_low_uf", 64'(fifo_rd_underflow), 64'd0);
        s_axis_xfer_req = 1;
        @(negedge clk);
        chk("xfer_flushed_uf", 64'(fifo_rd_underflow), 64'd1);
        chk("xfer_flushed_valid", 64'(fifo_rd_valid), 64'd0);
        fifo_rd_en = 0;

        // Timestamp mode: 4 sets of 3 per packet, tail samples 13..16 and 29..32 discarded
        timestamp = 90;
        do_reset(4'b0111, 4);
        ts_run = 1;
        for (int s = 0; s < 4; s++) exp_q.push_back('{d: mkset(4'b0111, 3 * s + 1), min_ts: 64'd100});
        for (int s = 0; s < 4; s++) exp_q.push_back('{d: mkset(4'b0111, 3 * s + 17), min_ts: 64'd130});
        fifo_rd_en = 1;
        send({64'hFFFF_0000_ABCD_1234, 64'd100});
        send(beat(1));
        send(beat(9));
        send({64'h1111_2222_3333_4444, 64'd130});
        send(beat(17));
        send(beat(25));
        drain();
        repeat (20) @(negedge clk);
        fifo_rd_en = 0;
        ts_run = 0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
